xts_sector_scheduler: RTL
=========================

Name: xts_sector_scheduler

Overview:
- Sequences one XTS-AES-256 sector through the shared AES block encrypt/decrypt core. Full 128-bit blocks only; no ciphertext stealing.
- Per sector it issues the tweak encryption first (always encrypt, tweak key), holds T, then runs each data block as pre-XOR T, core operation (data key, sector mode), post-XOR T.
- After each block, T advances by multiplication by alpha in GF(2^128).
- Sits between the host stream interface and the core's write/busy handshake; round-key delivery stays external, steered by outCoreKeySel.

Parameters:
CNT_W, 16, width of per-sector block count

Ports:
inClk  in  1  clock
inRst  in  1  synchronous active-high reset
inSectorStart  in  1  one-cycle pulse; samples inTweakIv, inBlockCount, inMode
inTweakIv  in  128  sector tweak before encryption
inBlockCount  in  CNT_W  number of data blocks in sector
inMode  in  1  0=encrypt, 1=decrypt
outSectorReady  out  1  high in IDLE when inCoreBusy=0; inSectorStart accepted only when high
inDataValid  in  1  input block valid
inData  in  128  input block
outDataReady  out  1  input block accepted when inDataValid & outDataReady
outDataValid  out  1  output block valid
outData  out  128  output block
inDataReady  in  1  downstream accepts when outDataValid & inDataReady
outCoreWr  out  1  one-cycle start pulse to core
outCoreMode  out  1  core mode: 0 enc, 1 dec
outCoreKeySel  out  1  0=data key, 1=tweak key; stable from issue until core done
outCoreData  out  128  core input block, registered
inCoreData  in  128  core result
inCoreBusy  in  1  core busy flag
outBusy  out  1  high in any state other than IDLE
outSectorDone  out  1  one-cycle pulse after last block is handed off

Behaviour:
- Reset values (synchronous, inRst=1):
  - state=IDLE.
  - outCoreWr, outDataValid, outDataReady, outSectorDone, outBusy = 0.
  - outCoreMode, outCoreKeySel = 0.
  - outData, outCoreData, T, count = 0.
- Reset mid-operation: abandons the sector immediately; no further outputs.
- After reset, IDLE holds outSectorReady low until inCoreBusy=0, so a core still running an abandoned operation is never re-triggered.
- States and transitions:
  - IDLE: inSectorStart & outSectorReady:
    - inBlockCount=0 -> DONE.
    - otherwise latch mode and count, outCoreData=inTweakIv, outCoreKeySel=1, outCoreMode=0 -> T_ISSUE.
    - inSectorStart while not ready is ignored, no latching.
  - T_ISSUE: outCoreWr=1 for exactly one cycle -> T_WSTART.
  - T_WSTART: wait for inCoreBusy=1 -> T_WDONE.
  - T_WDONE: on inCoreBusy=0, T<=inCoreData -> B_IN.
  - B_IN: outDataReady=1. On handshake: outCoreData<=inData^T, outCoreKeySel<=0, outCoreMode<=latched mode; outDataReady drops next cycle -> B_ISSUE.
  - B_ISSUE / B_WSTART / B_WDONE: same as tweak phase. On done: outData<=inCoreData^T, outDataValid<=1 -> B_OUT.
  - B_OUT: outData held stable while inDataReady=0. On handshake:
    - outDataValid<=0, T<=alpha*T, count<=count-1.
    - count was 1 -> DONE; else -> B_IN.
  - DONE: outSectorDone=1 for one cycle -> IDLE.
- alpha multiply: bit i of T is coefficient of x^i (byte order handled upstream). T_next = {T[126:0],1'b0} ^ (T[127] ? 128'h87 : 0).
- Core handshake: each operation waits for the busy rise then the fall, independent of core latency. Exactly one outCoreWr per operation. No core write while inCoreBusy=1.
- Throughput: one block in flight. Minimum 2 cycles overhead per block beyond core latency plus both stream handshakes.
- Tweak encryption is always mode 0 with key select 1, regardless of sector mode.
- inBlockCount = 2^CNT_W-1 is legal; no wrap, count decrements to 0 exactly once.

Test Plan:
- Bench core model: latency 10 cycles, result = in ^ {64'h0, keysel, mode, 62'h0} ^ 128'hA5A5...A5.
- Encrypt sector, count=3, IV=0, data 1,2,3 -> tweak write seen with keysel=1, mode=0. Outputs match model with T0=IV-op, T1=alpha*T0, T2=alpha*T1. Exactly 4 outCoreWr pulses. One outSectorDone after third output handshake.
- GF wrap: force T0=128'h8000_0000_0000_0000_0000_0000_0000_0000 (IV chosen via model inverse) -> block-2 XOR uses T=128'h87.
- Backpressure: inDataReady low 20 cycles in B_OUT -> outData stable, no new outDataReady, no core write; resumes correctly.
- count=0 -> no outCoreWr, outSectorDone pulses 1 cycle after start, outBusy high exactly 1 cycle.
- inRst asserted during B_WDONE with model core still busy -> all outputs zero next cycle. outSectorReady stays low until model busy drops. Start pulse before that is ignored; start after completes a normal sector.
- Decrypt sector, count=2 -> tweak op mode 0, data ops mode 1 keysel 0. inSectorStart during sector ignored, no state change.

Source files
------------

// File: rtl/xts_sector_scheduler.sv
// XTS-AES sector sequencer: one tweak encryption, then per-block pre-XOR / core op / post-XOR,
// with the tweak advanced by alpha in GF(2^128) after each block hand-off.
module xts_sector_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic               inClk,
    input  logic               inRst,
    input  logic               inSectorStart,
    input  logic [127:0]       inTweakIv,
    input  logic [CNT_W-1:0]   inBlockCount,
    input  logic               inMode,
    output logic               outSectorReady,
    input  logic               inDataValid,
    input  logic [127:0]       inData,
    output logic               outDataReady,
    output logic               outDataValid,
    output logic [127:0]       outData,
    input  logic               inDataReady,
    output logic               outCoreWr,
    output logic               outCoreMode,
    output logic               outCoreKeySel,
    output logic [127:0]       outCoreData,
    input  logic [127:0]       inCoreData,
    input  logic               inCoreBusy,
    output logic               outBusy,
    output logic               outSectorDone
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_T_ISSUE  = 4'd1;
    localparam logic [3:0] S_T_WSTART = 4'd2;
    localparam logic [3:0] S_T_WDONE  = 4'd3;
    localparam logic [3:0] S_B_IN     = 4'd4;
    localparam logic [3:0] S_B_ISSUE  = 4'd5;
    localparam logic [3:0] S_B_WSTART = 4'd6;
    localparam logic [3:0] S_B_WDONE  = 4'd7;
    localparam logic [3:0] S_B_OUT    = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       state_q, state_d;
    logic [127:0]     tweak_q, tweak_d;
    logic [127:0]     out_data_q, out_data_d;
    logic [127:0]     core_data_q, core_data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             key_sel_q, key_sel_d;
    logic             core_mode_q, core_mode_d;
    logic             out_valid_q, out_valid_d;
    logic             sector_ready_s;

    // Multiply by x modulo x^128 + x^7 + x^2 + x + 1; bit i is the coefficient of x^i.
    function automatic logic [127:0] gf_mul_alpha(input logic [127:0] t);
        return {t[126:0], 1'b0} ^ (t[127] ? 128'h87 : 128'h0);
    endfunction

    // Never start while the core may still be finishing an abandoned operation.
    assign sector_ready_s = (state_q == S_IDLE) && !inCoreBusy;

    // Next-state and datapath updates for the sector sequence.
    always_comb begin
        state_d     = state_q;
        tweak_d     = tweak_q;
        out_data_d  = out_data_q;
        core_data_d = core_data_q;
        count_d     = count_q;
        mode_d      = mode_q;
        key_sel_d   = key_sel_q;
        core_mode_d = core_mode_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (inSectorStart && sector_ready_s) begin
                    if (inBlockCount == CNT_ZERO) begin
                        state_d = S_DONE;
                    end else begin
                        mode_d      = inMode;
                        count_d     = inBlockCount;
                        core_data_d = inTweakIv;
                        key_sel_d   = 1'b1;
                        core_mode_d = 1'b0;
                        state_d     = S_T_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T_ISSUE: state_d = S_T_WSTART;
            S_T_WSTART: begin
                if (inCoreBusy) state_d = S_T_WDONE;
                else            state_d = S_T_WSTART;
            end
            S_T_WDONE: begin
                if (!inCoreBusy) begin
                    tweak_d = inCoreData;
                    state_d = S_B_IN;
                end else begin
                    state_d = S_T_WDONE;
                end
            end
            S_B_IN: begin
                if (inDataValid) begin
                    core_data_d = inData ^ tweak_q;
                    key_sel_d   = 1'b0;
                    core_mode_d = mode_q;
                    state_d     = S_B_ISSUE;
                end else begin
                    state_d = S_B_IN;
                end
            end
            S_B_ISSUE: state_d = S_B_WSTART;
            S_B_WSTART: begin
                if (inCoreBusy) state_d = S_B_WDONE;
                else            state_d = S_B_WSTART;
            end
            S_B_WDONE: begin
                if (!inCoreBusy) begin
                    out_data_d  = inCoreData ^ tweak_q;
                    out_valid_d = 1'b1;
                    state_d     = S_B_OUT;
                end else begin
                    state_d = S_B_WDONE;
                end
            end
            S_B_OUT: begin
                if (inDataReady) begin
                    out_valid_d = 1'b0;
                    tweak_d     = gf_mul_alpha(tweak_q);
                    count_d     = count_q - CNT_ONE;
                    if (count_q == CNT_ONE) state_d = S_DONE;
                    else                    state_d = S_B_IN;
                end else begin
                    state_d = S_B_OUT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            state_q     <= S_IDLE;
            tweak_q     <= 128'h0;
            out_data_q  <= 128'h0;
            core_data_q <= 128'h0;
            count_q     <= CNT_ZERO;
            mode_q      <= 1'b0;
            key_sel_q   <= 1'b0;
            core_mode_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tweak_q     <= tweak_d;
            out_data_q  <= out_data_d;
            core_data_q <= core_data_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            key_sel_q   <= key_sel_d;
            core_mode_q <= core_mode_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign outSectorReady = sector_ready_s;
    assign outDataReady   = (state_q == S_B_IN);
    assign outDataValid   = out_valid_q;
    assign outData        = out_data_q;
    assign outCoreWr      = (state_q == S_T_ISSUE) || (state_q == S_B_ISSUE);
    assign outCoreMode    = core_mode_q;
    assign outCoreKeySel  = key_sel_q;
    assign outCoreData    = core_data_q;
    assign outBusy        = (state_q != S_IDLE);
    assign outSectorDone  = (state_q == S_DONE);

endmodule
